// File: rtl/response_frame_tx.sv
// rtl/response_frame_tx.sv - framed UART response sender: sync, length, FIFO payload, xor checksum
// One byte at a time is handed to the UART through a tx_enable/tx_busy handshake.
module response_frame_tx #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] frame_len,
  output logic       busy,
  output logic       done,
  output logic [1:0] err_code,
  input  logic       fifo_empty,
  output logic       fifo_re,
  input  logic [7:0] fifo_data,
  input  logic       tx_busy,
  output logic       tx_enable,
  output logic [7:0] tx_data
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  // The timer starts at 0 in the first TX_ACK cycle, i.e. one cycle after tx_enable,
  // so this value marks the last cycle that still fits inside ACK_TIMEOUT.
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 2);

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_UNDERRUN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_LEN,
    S_FETCH,
    S_LATCH,
    S_CSUM,
    S_TX_ISSUE,
    S_TX_ACK,
    S_TX_WAIT,
    S_FINISH
  } state_t;

  state_t          state_q, state_d;
  state_t          ret_q, ret_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      csum_q, csum_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [1:0]      err_q, err_d;
  logic [TW-1:0]   timer_q, timer_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ret_q     <= S_IDLE;
      len_q     <= 8'd0;
      cnt_q     <= 8'd0;
      csum_q    <= 8'd0;
      tx_data_q <= 8'd0;
      err_q     <= ERR_OK;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      csum_q    <= csum_d;
      tx_data_q <= tx_data_d;
      err_q     <= err_d;
      timer_q   <= timer_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    csum_d    = csum_q;
    tx_data_d = tx_data_q;
    err_d     = err_q;
    timer_d   = timer_q;
    fifo_re   = 1'b0;
    tx_enable = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = frame_len;
          csum_d  = frame_len;
          cnt_d   = 8'd0;
          err_d   = ERR_OK;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        tx_data_d = SYNC_BYTE;
        ret_d     = S_LEN;
        state_d   = S_TX_ISSUE;
      end
      S_LEN: begin
        tx_data_d = len_q;
        ret_d     = (len_q == 8'd0) ? S_CSUM : S_FETCH;
        state_d   = S_TX_ISSUE;
      end
      // An underrun abandons the frame without a checksum byte.
      S_FETCH: begin
        if (fifo_empty) begin
          err_d   = ERR_UNDERRUN;
          state_d = S_FINISH;
        end else begin
          fifo_re = 1'b1;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        tx_data_d = fifo_data;
        csum_d    = csum_q ^ fifo_data;
        cnt_d     = cnt_q + 8'd1;
        ret_d     = ((cnt_q + 8'd1) == len_q) ? S_CSUM : S_FETCH;
        state_d   = S_TX_ISSUE;
      end
      S_CSUM: begin
        tx_data_d = csum_q;
        ret_d     = S_FINISH;
        state_d   = S_TX_ISSUE;
      end
      S_TX_ISSUE: begin
        if (!tx_busy) begin
          tx_enable = 1'b1;
          timer_d   = '0;
          state_d   = S_TX_ACK;
        end
      end
      S_TX_ACK: begin
        if (tx_busy) begin
          state_d = S_TX_WAIT;
        end else if (timer_q == TIMER_LAST) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_FINISH;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_TX_WAIT: begin
        if (!tx_busy) begin
          state_d = ret_q;
        end
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Equivalent to a flag set on accepted start and cleared the cycle after done.
  assign busy     = (state_q != S_IDLE);
  assign err_code = err_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_response_frame_tx.sv
// tb/tb_response_frame_tx.sv - bench for response_frame_tx with FIFO and UART models
// Expected frames come from a byte-list reference model built from the framing rules.
module tb_response_frame_tx;

  localparam logic [7:0] SYNC   = 8'hA5;
  localparam int         ACK_TO = 15;
  localparam int         BUDGET = 4000;

  logic       clk       = 1'b0;
  logic       reset_n   = 1'b0;
  logic       start     = 1'b0;
  logic [7:0] frame_len = 8'd0;
  logic       busy;
  logic       done;
  logic [1:0] err_code;
  logic       fifo_empty = 1'b1;
  logic       fifo_re;
  logic [7:0] fifo_data  = 8'd0;
  logic       tx_busy    = 1'b0;
  logic       tx_enable;
  logic [7:0] tx_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] obs_q[$];
  int   re_cnt = 0, re_empty = 0, done_cnt = 0, en_busy = 0, en_cnt = 0, unstable = 0;
  int   en_cyc = 0, done_cyc = 0;
  logic [1:0] done_err = 2'b00;
  int   uart_hold = 10;
  bit   uart_mute = 1'b0;
  int   busy_left = 0;

  response_frame_tx #(.SYNC_BYTE(8'hA5), .ACK_TIMEOUT(15)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .frame_len  (frame_len),
    .busy       (busy),
    .done       (done),
    .err_code   (err_code),
    .fifo_empty (fifo_empty),
    .fifo_re    (fifo_re),
    .fifo_data  (fifo_data),
    .tx_busy    (tx_busy),
    .tx_enable  (tx_enable),
    .tx_data    (tx_data)
  );

  always #5 clk = ~clk;

  // FIFO: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_re && fifo_q.size() > 0) begin
      fifo_data  <= fifo_q.pop_front();
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // UART: busy rises one cycle after tx_enable and stays high uart_hold cycles.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_busy   <= 1'b0;
      busy_left <= 0;
    end else if (tx_enable && !uart_mute) begin
      tx_busy   <= 1'b1;
      busy_left <= uart_hold;
    end else if (busy_left > 1) begin
      busy_left <= busy_left - 1;
    end else begin
      tx_busy   <= 1'b0;
      busy_left <= 0;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (fifo_re) begin
        re_cnt++;
        if (fifo_empty) re_empty++;
      end
      if (tx_enable) begin
        obs_q.push_back(tx_data);
        en_cnt++;
        en_cyc = cyc;
        if (tx_busy) en_busy++;
      end
      if (tx_busy && obs_q.size() > 0 && tx_data !== obs_q[$]) unstable++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_err = err_code;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counters();
    re_cnt = 0; re_empty = 0; done_cnt = 0; en_busy = 0; en_cnt = 0; unstable = 0;
    obs_q.delete();
  endtask

  function automatic void ref_frame(input int len, input logic [7:0] pay[$], input int avail,
                                    output logic [7:0] exp[$], output int exp_re,
                                    output logic [1:0] exp_err);
    logic [7:0] sum;
    logic [7:0] len8;
    len8 = len[7:0];
    exp.delete();
    exp.push_back(SYNC);
    exp.push_back(len8);
    sum = len8;
    if (avail >= len) begin
      for (int i = 0; i < len; i++) begin
        exp.push_back(pay[i]);
        sum = sum ^ pay[i];
      end
      exp.push_back(sum);
      exp_re  = len;
      exp_err = 2'b00;
    end else begin
      for (int i = 0; i < avail; i++) exp.push_back(pay[i]);
      exp_re  = avail;
      exp_err = 2'b01;
    end
  endfunction

  task automatic load_fifo(input logic [7:0] pay[$], input int avail);
    fifo_q.delete();
    for (int i = 0; i < avail; i++) fifo_q.push_back(pay[i]);
    fifo_empty = (avail == 0);
  endtask

  task automatic run_frame(input string tag, input int len, input logic [7:0] pay[$],
                           input int avail, input int hold, input bit poke);
    logic [7:0] exp[$];
    int         exp_re;
    logic [1:0] exp_err;
    bit         seen;
    logic [7:0] got;
    ref_frame(len, pay, avail, exp, exp_re, exp_err);
    clear_counters();
    uart_hold = hold;
    uart_mute = 1'b0;
    load_fifo(pay, avail);
    start     = 1'b1;
    frame_len = len[7:0];
    @(negedge clk);
    start     = 1'b0;
    frame_len = 8'($urandom);
    seen = 1'b0;
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge clk);
      start = poke && (k == 5 || done);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, ":done_seen"}, 64'(seen), 64'd1);
    check({tag, ":done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, ":err_code"}, 64'(done_err), 64'(exp_err));
    check({tag, ":err_held"}, 64'(err_code), 64'(exp_err));
    check({tag, ":fifo_re_count"}, 64'(re_cnt), 64'(exp_re));
    check({tag, ":re_when_empty"}, 64'(re_empty), 64'd0);
    check({tag, ":en_while_busy"}, 64'(en_busy), 64'd0);
    check({tag, ":tx_data_stable"}, 64'(unstable), 64'd0);
    check({tag, ":busy_after"}, 64'(busy), 64'd0);
    check({tag, ":byte_count"}, 64'(obs_q.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 8'hxx;
      check($sformatf("%s:byte%0d", tag, i), 64'(got), 64'(exp[i]));
    end
  endtask

  initial begin
    logic [7:0] p[$];
    bit         seen;
    logic [7:0] first;
    int         len;
    int         avail;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset:busy", 64'(busy), 64'd0);
    check("reset:done", 64'(done), 64'd0);
    check("reset:fifo_re", 64'(fifo_re), 64'd0);
    check("reset:tx_enable", 64'(tx_enable), 64'd0);
    check("reset:tx_data", 64'(tx_data), 64'd0);
    check("reset:err_code", 64'(err_code), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    p.delete(); p.push_back(8'h11); p.push_back(8'h22); p.push_back(8'h33);
    run_frame("t1_len3", 3, p, 3, 10, 1'b0);

    p.delete();
    run_frame("t2_len0", 0, p, 0, 3, 1'b0);

    p.delete();
    for (int i = 0; i < 4; i++) p.push_back(8'($urandom));
    run_frame("t3_underrun", 4, p, 2, 2, 1'b0);

    // Ack timeout: the UART never answers the sync byte.
    clear_counters();
    uart_mute = 1'b1;
    p.delete(); p.push_back(8'h44); p.push_back(8'h55);
    load_fifo(p, 2);
    start = 1'b1; frame_len = 8'd2;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
    first = (obs_q.size() > 0) ? obs_q[0] : 8'hxx;
    check("t4:done_seen", 64'(seen), 64'd1);
    check("t4:err_code", 64'(done_err), 64'd2);
    check("t4:enable_count", 64'(en_cnt), 64'd1);
    check("t4:first_byte", 64'(first), 64'(SYNC));
    check("t4:ack_latency", 64'(done_cyc - en_cyc), 64'(ACK_TO));
    check("t4:fifo_re_count", 64'(re_cnt), 64'd0);
    check("t4:busy_after", 64'(busy), 64'd0);
    uart_mute = 1'b0;

    // Reset in the middle of the payload.
    clear_counters();
    uart_hold = 4;
    p.delete(); p.push_back(8'h01); p.push_back(8'h02); p.push_back(8'h03);
    load_fifo(p, 3);
    start = 1'b1; frame_len = 8'd3;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge clk);
      if (re_cnt >= 2) begin seen = 1'b1; break; end
    end
    check("t5:reached_byte2", 64'(seen), 64'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t5:busy", 64'(busy), 64'd0);
    check("t5:done", 64'(done), 64'd0);
    check("t5:fifo_re", 64'(fifo_re), 64'd0);
    check("t5:tx_enable", 64'(tx_enable), 64'd0);
    check("t5:tx_data", 64'(tx_data), 64'd0);
    check("t5:err_code", 64'(err_code), 64'd0);
    repeat (3) @(negedge clk);
    check("t5:no_done", 64'(done_cnt), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    p.delete(); p.push_back(8'h5A);
    run_frame("t5_after", 1, p, 1, 10, 1'b0);

    p.delete(); p.push_back(8'h0F); p.push_back(8'hF0); p.push_back(8'h3C);
    run_frame("t6_poke", 3, p, 3, 3, 1'b1);

    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(0, 12);
      avail = ($urandom_range(0, 3) == 0 && len > 0) ? $urandom_range(0, len - 1) : len;
      p.delete();
      for (int i = 0; i < len; i++) p.push_back(8'($urandom));
      run_frame($sformatf("rand%0d", r), len, p, avail, $urandom_range(1, 6), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
